// File: rtl/cpu_clk_sched.sv
// CPU clock-enable scheduler: free run / halt / single step / N-tick burst at period div_reg+1.
// Latency: first cpu_en div_reg+1 cycles after the command edge; no backpressure, commands are single-cycle pulses.
module cpu_clk_sched #(
  parameter int DIV_WIDTH = 24,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 24'd49999,
  parameter int BURST_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIV_WIDTH-1:0]   div_value,
  input  logic                   div_load,
  input  logic                   cmd_run,
  input  logic                   cmd_halt,
  input  logic                   cmd_step,
  input  logic                   cmd_burst,
  input  logic [BURST_WIDTH-1:0] burst_count,
  output logic                   cpu_en,
  output logic                   busy,
  output logic [1:0]             state,
  output logic [BURST_WIDTH-1:0] burst_left
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    BURST = 2'b11
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [BURST_WIDTH-1:0] left_q, left_d;
  logic                   tick;

  assign tick = (state_q != IDLE) && (cnt_q == div_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    div_d   = div_q;

    if (state_q != IDLE) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_step) begin
          state_d = STEP;
        end else if (cmd_burst && (burst_count != '0)) begin
          state_d = BURST;
          left_d  = burst_count;
        end else if (cmd_run) begin
          state_d = RUN;
        end
      end
      STEP: begin
        if (tick) state_d = IDLE;
      end
      BURST: begin
        // Switching to free run keeps cnt so the tick phase does not jump.
        if (cmd_run) begin
          state_d = RUN;
          left_d  = '0;
        end else if (tick) begin
          left_d = left_q - 1'b1;
          if (left_q == 1) state_d = IDLE;
        end
      end
      default: ;
    endcase

    if (cmd_halt) begin
      state_d = IDLE;
      left_d  = '0;
    end

    if (state_d == IDLE) cnt_d = '0;

    // A reload restarts a full period, even if a tick was pending.
    if (div_load) begin
      div_d = div_value;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DEFAULT_DIV;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      left_q  <= left_d;
    end
  end

  assign cpu_en     = tick;
  assign busy       = (state_q != IDLE);
  assign state      = state_q;
  assign burst_left = left_q;

endmodule

// File: tb/tb_cpu_clk_sched.sv
// Bench for cpu_clk_sched: vector table, directed multi-cycle sequences, random run against a reference model.
module tb_cpu_clk_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] div_value = '0;
  logic        div_load = 1'b0;
  logic        cmd_run = 1'b0;
  logic        cmd_halt = 1'b0;
  logic        cmd_step = 1'b0;
  logic        cmd_burst = 1'b0;
  logic [15:0] burst_count = '0;
  logic        cpu_en;
  logic        busy;
  logic [1:0]  state;
  logic [15:0] burst_left;

  int total = 0;
  int bad = 0;

  cpu_clk_sched dut (
    .clk(clk), .rst(rst), .div_value(div_value), .div_load(div_load),
    .cmd_run(cmd_run), .cmd_halt(cmd_halt), .cmd_step(cmd_step),
    .cmd_burst(cmd_burst), .burst_count(burst_count),
    .cpu_en(cpu_en), .busy(busy), .state(state), .burst_left(burst_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ld;
    logic [23:0] dv;
    logic        run, halt, step, burst;
    logic [15:0] bc;
    logic        en;
    logic [1:0]  st;
    logic [15:0] left;
  } vec_t;

  vec_t tbl[15];

  // Reference model: ticks still owed (-1 = unbounded), kind of activity,
  // cycles elapsed in the current period, and divider.
  int          m_rem, m_pos, m_div;
  logic [1:0]  m_kind;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are set at a negedge, held over one posedge, then cleared.
  task automatic drive(input logic r, input logic ld, input int dv, input logic ru,
                       input logic ha, input logic st, input logic bu, input int bc);
    rst = r; div_load = ld; div_value = 24'(dv);
    cmd_run = ru; cmd_halt = ha; cmd_step = st; cmd_burst = bu;
    burst_count = 16'(bc);
    @(negedge clk);
    rst = 1'b0; div_load = 1'b0; cmd_run = 1'b0; cmd_halt = 1'b0;
    cmd_step = 1'b0; cmd_burst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic model_step(input logic r, input logic ld, input int dv, input logic ru,
                            input logic ha, input logic st, input logic bu, input int bc);
    bit tick, was_active;
    tick = (m_rem != 0) && (m_pos == m_div);
    was_active = (m_rem != 0);
    if (r) begin
      m_rem = 0; m_pos = 0; m_div = 49999; m_kind = 2'd0;
      return;
    end
    if (ha) m_rem = 0;
    else if (m_rem == 0) begin
      if (st) begin m_rem = 1; m_kind = 2'd2; end
      else if (bu && bc != 0) begin m_rem = bc; m_kind = 2'd3; end
      else if (ru) begin m_rem = -1; m_kind = 2'd1; end
    end else if (m_kind == 2'd3 && ru) begin
      m_rem = -1; m_kind = 2'd1;
    end else if (tick && m_rem > 0) m_rem--;
    if (ld || m_rem == 0 || !was_active) m_pos = 0;
    else m_pos = tick ? 0 : m_pos + 1;
    if (ld) m_div = dv;
  endtask

  initial begin
    //          rst ld dv run halt step burst bc  en st left
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 1, 0, 0,  1, 2, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    tbl[5]  = '{0, 1, 1, 0, 0, 0, 1, 2,  0, 3, 2};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 3, 2};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 3, 1};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 3, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0};
    tbl[11] = '{0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0};
    tbl[12] = '{0, 0, 0, 1, 0, 1, 0, 0,  0, 2, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 3,  1, 2, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ld, int'(tbl[i].dv), tbl[i].run, tbl[i].halt,
            tbl[i].step, tbl[i].burst, int'(tbl[i].bc));
      chk($sformatf("vec%0d_en", i), int'(cpu_en), int'(tbl[i].en));
      chk($sformatf("vec%0d_state", i), int'(state), int'(tbl[i].st));
      chk($sformatf("vec%0d_left", i), int'(burst_left), int'(tbl[i].left));
    end

    // Free run at div 3: tick every 4th cycle, first in cycle 4.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_div", int'(dut.div_q), 49999);
    drive(0, 1, 3, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("run_en_c%0d", c), int'(cpu_en), int'(c % 4 == 0));
      chk("run_state", int'(state), 1);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 1, 0, 0, 0);

    // Burst of 5 at div 2, then a zero-count burst.
    drive(0, 1, 2, 0, 0, 0, 1, 5);
    for (int c = 1; c <= 15; c++) begin
      chk($sformatf("burst_en_c%0d", c), int'(cpu_en), int'(c % 3 == 0));
      chk($sformatf("burst_left_c%0d", c), int'(burst_left), 5 - (c - 1) / 3);
      chk("burst_state", int'(state), 3);
      @(negedge clk);
    end
    chk("burst_end_state", int'(state), 0);
    chk("burst_end_left", int'(burst_left), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 6; c++) begin
      chk("burst0_en", int'(cpu_en), 0);
      chk("burst0_state", int'(state), 0);
      @(negedge clk);
    end

    // Halt in RUN at cnt 5, then halt+run together.
    drive(0, 1, 9, 1, 0, 0, 0, 0);
    idle(5);
    chk("halt_pre_cnt", int'(dut.cnt_q), 5);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    for (int c = 0; c < 15; c++) begin
      chk("halt_en", int'(cpu_en), 0);
      chk("halt_busy", int'(busy), 0);
      chk("halt_cnt", int'(dut.cnt_q), 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 1, 1, 0, 0, 0);
    chk("halt_run_state", int'(state), 0);
    idle(3);
    chk("halt_run_state_later", int'(state), 0);

    // Reload div 1 at cnt 7 during RUN at div 9.
    drive(0, 1, 9, 1, 0, 0, 0, 0);
    idle(7);
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("reload_en_c%0d", c), int'(cpu_en), int'(c % 2 == 0));
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 1, 0, 0, 0);

    // Reset in the middle of a burst with 3 ticks owed.
    drive(0, 1, 0, 0, 0, 0, 1, 5);
    idle(2);
    chk("midburst_left", int'(burst_left), 3);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_en", int'(cpu_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_left", int'(burst_left), 0);
    chk("rst_div", int'(dut.div_q), 49999);

    // Random commands against the reference model.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic r, ld, ru, ha, st, bu;
      int dv, bc;
      r  = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 29) == 0) || (n == 0);
      ha = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 19) == 0);
      bu = ($urandom_range(0, 24) == 0);
      ru = ($urandom_range(0, 24) == 0);
      dv = $urandom_range(0, 5);
      bc = ru ? $urandom_range(1, 12) : $urandom_range(0, 12);
      model_step(r, ld, dv, ru, ha, st, bu, bc);
      drive(r, ld, dv, ru, ha, st, bu, bc);
      chk("rand_en", int'(cpu_en), int'(m_rem != 0 && m_pos == m_div));
      chk("rand_state", int'(state), (m_rem == 0) ? 0 : int'(m_kind));
      chk("rand_busy", int'(busy), int'(m_rem != 0));
      chk("rand_left", int'(burst_left), (m_rem > 0 && m_kind == 2'd3) ? m_rem : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
